// File: rtl/uart_mem_loader.sv
// Boot loader: receives SYNC, LEN, data, SUM over 8N1 UART and writes data to memory from address 0.
// States: IDLE wait sync | GET_LEN length byte | DATA write bytes | GET_SUM checksum | DONE pulse done
module uart_mem_loader #(
  parameter int          CLKS_PER_BIT   = 234,
  parameter int          WORD_SIZE      = 8,
  parameter int          ADDRESS_SIZE   = 8,
  parameter int          TIMEOUT_CYCLES = 2700000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rx,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]    mem_w_data,
  output logic                    mem_w_en,
  output logic                    cpu_hold,
  output logic                    done,
  output logic                    err
);
  localparam int BTW = $clog2(CLKS_PER_BIT + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BTW-1:0] FULL_LD = BTW'(CLKS_PER_BIT - 1);
  localparam logic [BTW-1:0] HALF_LD = BTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TOW-1:0] TO_LD   = TOW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, GET_LEN, DATA, GET_SUM, DONE} ld_state_t;

  rx_state_t rx_state, rx_nxt;
  ld_state_t ld_state, ld_nxt;

  logic rx_s1, rx_s2, rx_d, fall;
  logic [BTW-1:0] bit_tmr;
  logic [2:0] bit_cnt;
  logic [WORD_SIZE-1:0] rx_byte;
  logic rx_valid, rx_ferr;
  logic load_half, load_full, shift, rx_good, rx_bad;

  logic [TOW-1:0] to_cnt;
  logic [WORD_SIZE-1:0] cnt, sum;
  logic [ADDRESS_SIZE-1:0] addr;
  logic accept_sync, take_len, take_data, finish_ok, fail, abort;

  assign fall = rx_d & ~rx_s2;

  always_comb begin
    rx_nxt    = rx_state;
    load_half = 1'b0;
    load_full = 1'b0;
    shift     = 1'b0;
    rx_good   = 1'b0;
    rx_bad    = 1'b0;
    case (rx_state)
      RX_IDLE:  if (fall) begin rx_nxt = RX_START; load_half = 1'b1; end
      RX_START: if (bit_tmr == '0) begin
                  if (rx_s2) rx_nxt = RX_IDLE;
                  else begin rx_nxt = RX_DATA; load_full = 1'b1; end
                end
      RX_DATA:  if (bit_tmr == '0) begin
                  shift     = 1'b1;
                  load_full = 1'b1;
                  if (bit_cnt == 3'd7) rx_nxt = RX_STOP;
                end
      RX_STOP:  if (bit_tmr == '0) begin
                  rx_nxt  = RX_IDLE;
                  rx_good = rx_s2;
                  rx_bad  = ~rx_s2;
                end
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= RX_IDLE;
      bit_tmr  <= '0;
      bit_cnt  <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      rx_state <= rx_nxt;
      rx_valid <= rx_good;
      rx_ferr  <= rx_bad;
      if (load_half)            bit_tmr <= HALF_LD;
      else if (load_full)       bit_tmr <= FULL_LD;
      else if (bit_tmr != '0)   bit_tmr <= bit_tmr - 1'b1;
      if (rx_state == RX_IDLE)  bit_cnt <= '0;
      else if (shift)           bit_cnt <= bit_cnt + 1'b1;
      if (shift)                rx_byte <= {rx_s2, rx_byte[WORD_SIZE-1:1]};
    end
  end

  // Abort only while a frame is open; DONE is a single cleanup cycle.
  always_comb begin
    ld_nxt      = ld_state;
    accept_sync = 1'b0;
    take_len    = 1'b0;
    take_data   = 1'b0;
    finish_ok   = 1'b0;
    fail        = 1'b0;
    abort       = (ld_state inside {GET_LEN, DATA, GET_SUM}) && (rx_ferr || to_cnt == '0);
    if (abort) begin
      fail   = 1'b1;
      ld_nxt = IDLE;
    end else begin
      case (ld_state)
        IDLE:    if (rx_valid && rx_byte == SYNC_BYTE) begin
                   accept_sync = 1'b1;
                   ld_nxt      = GET_LEN;
                 end
        GET_LEN: if (rx_valid) begin
                   take_len = 1'b1;
                   ld_nxt   = (rx_byte == '0) ? GET_SUM : DATA;
                 end
        DATA:    if (rx_valid) begin
                   take_data = 1'b1;
                   if (cnt == WORD_SIZE'(1)) ld_nxt = GET_SUM;
                 end
        GET_SUM: if (rx_valid) begin
                   if (rx_byte == sum) begin finish_ok = 1'b1; ld_nxt = DONE; end
                   else begin fail = 1'b1; ld_nxt = IDLE; end
                 end
        DONE:    ld_nxt = IDLE;
        default: ld_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state   <= IDLE;
      to_cnt     <= '0;
      cnt        <= '0;
      sum        <= '0;
      addr       <= '0;
      mem_addr   <= '0;
      mem_w_data <= '0;
      mem_w_en   <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ld_state <= ld_nxt;
      mem_w_en <= 1'b0;
      done     <= 1'b0;
      if (fall || accept_sync)                    to_cnt <= TO_LD;
      else if (ld_state != IDLE && to_cnt != '0)  to_cnt <= to_cnt - 1'b1;
      if (accept_sync) begin
        cpu_hold <= 1'b1;
        err      <= 1'b0;
      end
      if (take_len) begin
        cnt  <= rx_byte;
        addr <= '0;
        sum  <= '0;
      end
      if (take_data) begin
        mem_w_en   <= (addr != '1);
        mem_addr   <= addr;
        mem_w_data <= rx_byte;
        sum        <= sum + rx_byte;
        addr       <= addr + 1'b1;
        cnt        <= cnt - 1'b1;
      end
      if (finish_ok) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (fail) begin
        err      <= 1'b1;
        cpu_hold <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: frame table plus hand-written framing, timeout, glitch, full-length and reset cases.
module tb_uart_mem_loader;
  localparam int CPB = 8;
  localparam int TO  = 400;

  logic       clk, rst, uart_rx;
  logic [7:0] mem_addr, mem_w_data;
  logic       mem_w_en, cpu_hold, done, err;

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .WORD_SIZE(8), .ADDRESS_SIZE(8),
                    .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_w_en(mem_w_en), .cpu_hold(cpu_hold),
    .done(done), .err(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  int nw, ndone, hold_seen, done_bad, wide;
  logic [7:0] mem [256];
  logic [7:0] last_addr;
  logic wrote_ff, prev_wen;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_w_en) begin
        nw++;
        mem[mem_addr] = mem_w_data;
        last_addr = mem_addr;
        if (mem_addr == 8'hFF) wrote_ff = 1'b1;
        if (prev_wen) wide++;
      end
      if (done) begin
        ndone++;
        if (cpu_hold) done_bad++;
      end
      if (cpu_hold) hold_seen++;
      prev_wen = mem_w_en;
    end
  end

  task automatic clear_mon();
    nw = 0; ndone = 0; hold_seen = 0; done_bad = 0; wide = 0;
    wrote_ff = 1'b0; last_addr = 8'h00; prev_wen = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic settle();
    repeat (4 * CPB) @(negedge clk);
  endtask

  typedef struct {
    int          nb;
    logic [63:0] bytes;
    int          exp_nw;
    logic [23:0] exp_w;
    int          exp_done;
    logic        exp_err;
    logic        exp_hold_seen;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{nb:6, bytes:64'h0000_6633_2211_03A5, exp_nw:3, exp_w:24'h332211, exp_done:1, exp_err:1'b0, exp_hold_seen:1'b1};
    vecs[1] = '{nb:6, bytes:64'h0000_0033_2211_03A5, exp_nw:3, exp_w:24'h332211, exp_done:0, exp_err:1'b1, exp_hold_seen:1'b1};
    vecs[2] = '{nb:3, bytes:64'h0000_0000_0000_00A5, exp_nw:0, exp_w:24'h000000, exp_done:1, exp_err:1'b0, exp_hold_seen:1'b1};
    vecs[3] = '{nb:2, bytes:64'h0000_0000_0000_5A3C, exp_nw:0, exp_w:24'h000000, exp_done:0, exp_err:1'b0, exp_hold_seen:1'b0};
    vecs[4] = '{nb:5, bytes:64'h0000_00FF_5AA5_02A5, exp_nw:2, exp_w:24'h005AA5, exp_done:1, exp_err:1'b0, exp_hold_seen:1'b1};
    vecs[5] = '{nb:4, bytes:64'h0000_0000_8080_01A5, exp_nw:1, exp_w:24'h000080, exp_done:1, exp_err:1'b0, exp_hold_seen:1'b1};

    clear_mon();
    uart_rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset mem_w_en", mem_w_en, 0);
    chk("reset cpu_hold", cpu_hold, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_w_data", mem_w_data, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      clear_mon();
      for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].bytes[8*i +: 8], 1'b1);
      settle();
      chk($sformatf("vec%0d writes", v), nw, vecs[v].exp_nw);
      chk($sformatf("vec%0d done", v), ndone, vecs[v].exp_done);
      chk($sformatf("vec%0d err", v), err, vecs[v].exp_err);
      chk($sformatf("vec%0d cpu_hold end", v), cpu_hold, 0);
      chk($sformatf("vec%0d hold seen", v), hold_seen > 0, vecs[v].exp_hold_seen);
      chk($sformatf("vec%0d w_en width", v), wide, 0);
      chk($sformatf("vec%0d hold at done", v), done_bad, 0);
      for (int k = 0; k < vecs[v].exp_nw; k++)
        chk($sformatf("vec%0d mem[%0d]", v, k), mem[k], vecs[v].exp_w[8*k +: 8]);
    end

    // framing error on the second data byte, then recovery
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    settle();
    chk("ferr err", err, 1);
    chk("ferr cpu_hold", cpu_hold, 0);
    chk("ferr writes", nw, 1);
    chk("ferr mem[0]", mem[0], 8'h11);
    chk("ferr done", ndone, 0);
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h77, 1'b1);
    settle();
    chk("recover err", err, 0);
    chk("recover done", ndone, 1);
    chk("recover mem[0]", mem[0], 8'h77);

    // one-cycle glitch while waiting for LEN must not produce a byte
    clear_mon();
    send_byte(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h55, 1'b1);
    settle();
    chk("glitch writes", nw, 1);
    chk("glitch mem[0]", mem[0], 8'h55);
    chk("glitch done", ndone, 1);
    chk("glitch err", err, 0);

    // inter-byte timeout
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (50) @(negedge clk);
    chk("pre-timeout cpu_hold", cpu_hold, 1);
    chk("pre-timeout err", err, 0);
    repeat (TO + 50) @(negedge clk);
    chk("timeout err", err, 1);
    chk("timeout cpu_hold", cpu_hold, 0);
    chk("timeout writes", nw, 1);
    chk("timeout done", ndone, 0);

    // full length frame: data i at address i, sum of 0..254 = 0x81
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'hFF, 1'b1);
    for (int i = 0; i < 255; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h81, 1'b1);
    settle();
    chk("len255 writes", nw, 255);
    chk("len255 last addr", last_addr, 8'hFE);
    chk("len255 no io write", wrote_ff, 0);
    chk("len255 mem[FE]", mem[254], 8'hFE);
    chk("len255 mem[64]", mem[100], 8'd100);
    chk("len255 done", ndone, 1);
    chk("len255 err", err, 0);

    // async reset in the middle of a byte
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("pre-rst cpu_hold", cpu_hold, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst cpu_hold", cpu_hold, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_w_data", mem_w_data, 0);
    chk("rst mem_w_en", mem_w_en, 0);
    chk("rst err", err, 0);
    chk("rst done", done, 0);
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h42, 1'b1);
    settle();
    chk("post-rst done", ndone, 1);
    chk("post-rst mem[0]", mem[0], 8'h42);
    chk("post-rst writes", nw, 1);
    chk("post-rst err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
